// File: rtl/ls_issue_scheduler.sv
// Issue scheduler for a 16-entry load/store queue: in-order allocate and retire,
// oldest-legal-first selection into a registered valid/ready memory request.
module ls_issue_scheduler #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic             alloc_store,
  output logic             alloc_ready,
  output logic [PTR_W-1:0] alloc_idx,
  input  logic             rdy_valid,
  input  logic [PTR_W-1:0] rdy_idx,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [PTR_W-1:0] mem_req_idx,
  output logic             mem_req_store,
  input  logic             mem_done,
  input  logic [PTR_W-1:0] mem_done_idx,
  output logic             retire_valid,
  output logic [PTR_W-1:0] retire_idx,
  output logic [PTR_W-1:0] head_ptr,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d, store_q, store_d, ready_q, ready_d;
  logic [DEPTH-1:0] issued_q, issued_d, done_q, done_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             req_valid_q, req_valid_d, req_store_q, req_store_d;
  logic [PTR_W-1:0] req_idx_q, req_idx_d;
  logic             retire_valid_q, retire_valid_d;
  logic [PTR_W-1:0] retire_idx_q, retire_idx_d;

  logic             sel_valid, sel_store, blocked;
  logic [PTR_W-1:0] sel_idx, pos_idx;
  logic             load_en, retire_now, do_alloc;

  // Walk from the head; a pending (unissued) store fences every younger load.
  always_comb begin
    sel_valid = 1'b0;
    sel_store = 1'b0;
    sel_idx   = '0;
    blocked   = 1'b0;
    pos_idx   = '0;
    for (int p = 0; p < DEPTH; p++) begin
      pos_idx = head_q + PTR_W'(p);
      if (!sel_valid && !blocked && valid_q[pos_idx] && ready_q[pos_idx] &&
          !issued_q[pos_idx] && (!store_q[pos_idx] || p == 0)) begin
        sel_valid = 1'b1;
        sel_store = store_q[pos_idx];
        sel_idx   = pos_idx;
      end
      if (valid_q[pos_idx] && store_q[pos_idx] && !issued_q[pos_idx]) blocked = 1'b1;
    end
  end

  always_comb begin
    valid_d        = valid_q;
    store_d        = store_q;
    ready_d        = ready_q;
    issued_d       = issued_q;
    done_d         = done_q;
    head_d         = head_q;
    tail_d         = tail_q;
    req_valid_d    = req_valid_q;
    req_idx_d      = req_idx_q;
    req_store_d    = req_store_q;
    retire_valid_d = 1'b0;
    retire_idx_d   = retire_idx_q;
    load_en        = !req_valid_q || mem_req_ready;
    retire_now     = valid_q[head_q] && done_q[head_q];
    do_alloc       = alloc_valid && alloc_ready;

    if (rdy_valid && valid_q[rdy_idx]) ready_d[rdy_idx] = 1'b1;
    if (mem_done && valid_q[mem_done_idx] && issued_q[mem_done_idx])
      done_d[mem_done_idx] = 1'b1;

    if (load_en) begin
      req_valid_d = sel_valid;
      if (sel_valid) begin
        req_idx_d         = sel_idx;
        req_store_d       = sel_store;
        issued_d[sel_idx] = 1'b1;
      end
    end

    if (retire_now) begin
      retire_valid_d   = 1'b1;
      retire_idx_d     = head_q;
      valid_d[head_q]  = 1'b0;
      store_d[head_q]  = 1'b0;
      ready_d[head_q]  = 1'b0;
      issued_d[head_q] = 1'b0;
      done_d[head_q]   = 1'b0;
      head_d           = head_q + 1'b1;
    end

    // The tail slot is always free while alloc_ready, so it never aliases the retiring head.
    if (do_alloc) begin
      valid_d[tail_q]  = 1'b1;
      store_d[tail_q]  = alloc_store;
      ready_d[tail_q]  = 1'b0;
      issued_d[tail_q] = 1'b0;
      done_d[tail_q]   = 1'b0;
      tail_d           = tail_q + 1'b1;
    end

    count_d = count_q + (PTR_W+1)'(do_alloc) - (PTR_W+1)'(retire_now);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q        <= '0;
      store_q        <= '0;
      ready_q        <= '0;
      issued_q       <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      req_valid_q    <= 1'b0;
      req_idx_q      <= '0;
      req_store_q    <= 1'b0;
      retire_valid_q <= 1'b0;
      retire_idx_q   <= '0;
    end else begin
      valid_q        <= valid_d;
      store_q        <= store_d;
      ready_q        <= ready_d;
      issued_q       <= issued_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      req_valid_q    <= req_valid_d;
      req_idx_q      <= req_idx_d;
      req_store_q    <= req_store_d;
      retire_valid_q <= retire_valid_d;
      retire_idx_q   <= retire_idx_d;
    end
  end

  assign alloc_ready   = (count_q != FULL);
  assign alloc_idx     = tail_q;
  assign empty         = (count_q == '0);
  assign head_ptr      = head_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_idx   = req_idx_q;
  assign mem_req_store = req_store_q;
  assign retire_valid  = retire_valid_q;
  assign retire_idx    = retire_idx_q;

endmodule

// File: tb/tb_ls_issue_scheduler.sv
// Directed bench for ls_issue_scheduler: ordering, handshake hold, full queue,
// wrap-around ordering, flush and ignored pulses.
module tb_ls_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst, flush, alloc_valid, alloc_store, alloc_ready;
  logic [3:0] alloc_idx;
  logic       rdy_valid;
  logic [3:0] rdy_idx;
  logic       mem_req_valid, mem_req_ready, mem_req_store;
  logic [3:0] mem_req_idx;
  logic       mem_done;
  logic [3:0] mem_done_idx;
  logic       retire_valid;
  logic [3:0] retire_idx, head_ptr;
  logic       empty;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ls_issue_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_store(alloc_store),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .rdy_valid(rdy_valid), .rdy_idx(rdy_idx),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_idx(mem_req_idx), .mem_req_store(mem_req_store),
    .mem_done(mem_done), .mem_done_idx(mem_done_idx),
    .retire_valid(retire_valid), .retire_idx(retire_idx),
    .head_ptr(head_ptr), .empty(empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    flush = 1'b0; alloc_valid = 1'b0; alloc_store = 1'b0;
    rdy_valid = 1'b0; rdy_idx = '0; mem_req_ready = 1'b0;
    mem_done = 1'b0; mem_done_idx = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_alloc(input logic s);
    alloc_valid = 1'b1; alloc_store = s;
    tick();
    alloc_valid = 1'b0; alloc_store = 1'b0;
  endtask

  task automatic rdy(input logic [3:0] i);
    rdy_valid = 1'b1; rdy_idx = i;
    tick();
    rdy_valid = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_idx", mem_req_idx, 0);
    chk("rst_req_store", mem_req_store, 0);
    chk("rst_retire_valid", retire_valid, 0);
    chk("rst_retire_idx", retire_idx, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_idx", alloc_idx, 0);
    chk("rst_empty", empty, 1);
    chk("rst_head", head_ptr, 0);

    // Three loads, out-of-order readiness, in-order retire
    do_alloc(0); do_alloc(0); do_alloc(0);
    chk("s1_alloc_idx", alloc_idx, 3);
    chk("s1_not_empty", empty, 0);
    mem_req_ready = 1'b1;
    rdy_valid = 1'b1; rdy_idx = 2; tick();
    chk("s1_no_req_yet", mem_req_valid, 0);
    rdy_idx = 0; tick();
    chk("s1_req2_valid", mem_req_valid, 1);
    chk("s1_req2_idx", mem_req_idx, 2);
    rdy_idx = 1; tick();
    chk("s1_req0_idx", mem_req_idx, 0);
    rdy_valid = 1'b0; tick();
    chk("s1_req1_valid", mem_req_valid, 1);
    chk("s1_req1_idx", mem_req_idx, 1);
    tick();
    chk("s1_req_idle", mem_req_valid, 0);
    mem_done = 1'b1; mem_done_idx = 2; tick();
    chk("s1_no_retire_a", retire_valid, 0);
    mem_done_idx = 0; tick();
    chk("s1_no_retire_b", retire_valid, 0);
    mem_done_idx = 1; tick();
    chk("s1_ret0_valid", retire_valid, 1);
    chk("s1_ret0_idx", retire_idx, 0);
    chk("s1_head1", head_ptr, 1);
    mem_done = 1'b0; tick();
    chk("s1_ret1_idx", retire_idx, 1);
    tick();
    chk("s1_ret2_valid", retire_valid, 1);
    chk("s1_ret2_idx", retire_idx, 2);
    chk("s1_empty", empty, 1);
    chk("s1_head3", head_ptr, 3);
    tick();
    chk("s1_ret_pulse_end", retire_valid, 0);

    // Head store fences a ready load; request held while memory stalls
    do_reset();
    do_alloc(1); do_alloc(0);
    rdy(1); tick();
    chk("s2_store_blocks", mem_req_valid, 0);
    rdy(0);
    chk("s2_latency", mem_req_valid, 0);
    tick();
    chk("s2_st_valid", mem_req_valid, 1);
    chk("s2_st_idx", mem_req_idx, 0);
    chk("s2_st_store", mem_req_store, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("s2_hold_valid", mem_req_valid, 1);
      chk("s2_hold_idx", mem_req_idx, 0);
      chk("s2_hold_store", mem_req_store, 1);
    end
    mem_req_ready = 1'b1; tick();
    chk("s2_ld_valid", mem_req_valid, 1);
    chk("s2_ld_idx", mem_req_idx, 1);
    chk("s2_ld_store", mem_req_store, 0);
    tick();
    chk("s2_idle", mem_req_valid, 0);
    mem_done = 1'b1; mem_done_idx = 0; tick();
    mem_done_idx = 1; tick();
    chk("s2_ret0_valid", retire_valid, 1);
    chk("s2_ret0_idx", retire_idx, 0);
    mem_done = 1'b0; tick();
    chk("s2_ret1_idx", retire_idx, 1);
    chk("s2_empty", empty, 1);

    // Full queue: retire frees a slot only from the next cycle
    do_reset();
    mem_req_ready = 1'b1;
    alloc_valid = 1'b1;
    repeat (16) tick();
    alloc_valid = 1'b0;
    chk("s3_full_ready", alloc_ready, 0);
    chk("s3_full_idx", alloc_idx, 0);
    chk("s3_full_not_empty", empty, 0);
    rdy(0); tick();
    chk("s3_req0", mem_req_idx, 0);
    mem_done = 1'b1; mem_done_idx = 0; tick();
    mem_done = 1'b0; alloc_valid = 1'b1; tick();
    chk("s3_ret_valid", retire_valid, 1);
    chk("s3_ret_idx", retire_idx, 0);
    chk("s3_ready_after_ret", alloc_ready, 1);
    chk("s3_idx_not_taken", alloc_idx, 0);
    chk("s3_head1", head_ptr, 1);
    tick();
    alloc_valid = 1'b0;
    chk("s3_refull_ready", alloc_ready, 0);
    chk("s3_refull_idx", alloc_idx, 1);
    chk("s3_ret_pulse_end", retire_valid, 0);

    // Wrap-around ordering across 15 -> 0
    do_reset();
    mem_req_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      do_alloc(0);
      rdy(4'(k));
      tick();
      mem_done = 1'b1; mem_done_idx = 4'(k); tick();
      mem_done = 1'b0; tick();
      chk("s4_walk_ret_valid", retire_valid, 1);
      chk("s4_walk_ret_idx", retire_idx, 32'(k));
    end
    chk("s4_head14", head_ptr, 14);
    chk("s4_empty", empty, 1);
    do_alloc(0); do_alloc(1); do_alloc(0);
    rdy(0); rdy(15);
    chk("s4_none_a", mem_req_valid, 0);
    rdy(14);
    chk("s4_none_b", mem_req_valid, 0);
    tick();
    chk("s4_l14_valid", mem_req_valid, 1);
    chk("s4_l14_idx", mem_req_idx, 14);
    tick();
    chk("s4_l0_blocked_a", mem_req_valid, 0);
    mem_done = 1'b1; mem_done_idx = 14; tick();
    mem_done = 1'b0;
    chk("s4_l0_blocked_b", mem_req_valid, 0);
    tick();
    chk("s4_ret14_idx", retire_idx, 14);
    chk("s4_head15", head_ptr, 15);
    tick();
    chk("s4_s15_idx", mem_req_idx, 15);
    chk("s4_s15_store", mem_req_store, 1);
    tick();
    chk("s4_l0_valid", mem_req_valid, 1);
    chk("s4_l0_idx", mem_req_idx, 0);
    chk("s4_l0_store", mem_req_store, 0);

    // Flush with a pending request and two issued entries
    do_reset();
    repeat (5) do_alloc(0);
    rdy(0); rdy(3);
    chk("s5_req0", mem_req_idx, 0);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    chk("s5_req3_valid", mem_req_valid, 1);
    chk("s5_req3_idx", mem_req_idx, 3);
    flush = 1'b1; alloc_valid = 1'b1; rdy_valid = 1'b1; rdy_idx = 4;
    mem_done = 1'b1; mem_done_idx = 0;
    tick();
    clear_inputs();
    chk("s5_flush_req", mem_req_valid, 0);
    chk("s5_flush_empty", empty, 1);
    chk("s5_flush_head", head_ptr, 0);
    chk("s5_flush_alloc_idx", alloc_idx, 0);
    chk("s5_flush_alloc_ready", alloc_ready, 1);
    mem_done = 1'b1; mem_done_idx = 3; tick();
    mem_done = 1'b0;
    chk("s5_late_done_empty", empty, 1);
    tick();
    chk("s5_late_done_ret", retire_valid, 0);
    chk("s5_late_done_req", mem_req_valid, 0);

    // Pulses on invalid / non-issued entries are ignored
    mem_req_ready = 1'b1;
    rdy(1);
    do_alloc(0); do_alloc(0);
    tick();
    chk("s6_no_stale_ready", mem_req_valid, 0);
    mem_done = 1'b1; mem_done_idx = 0; tick();
    mem_done = 1'b0; tick();
    chk("s6_no_retire", retire_valid, 0);
    chk("s6_head", head_ptr, 0);
    chk("s6_alloc_idx", alloc_idx, 2);
    chk("s6_not_empty", empty, 0);
    rdy(0); tick();
    chk("s6_req_valid", mem_req_valid, 1);
    chk("s6_req_idx", mem_req_idx, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
